// File: rtl/imem_arbiter.sv
// Program-memory arbiter between instruction fetch and loader: round-robin with bounded loader
// burst lock, latency-matched read return routing. Optional IMEM_ARB_STATS_EN adds grant counters.
module imem_arbiter #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          CLB,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [15:0]   f_grant_cnt,
    output logic [15:0]   l_grant_cnt,
    output logic [15:0]   conflict_cnt
`endif
);

    typedef enum logic [0:0] {StArb, StLock} state_e;

    localparam logic       OwnFetch  = 1'b0;
    localparam logic       OwnLoader = 1'b1;
    localparam logic [3:0] MaxBurstC = 4'(MAX_BURST);

    state_e            state_q, state_d;
    logic              last_owner_q;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [RD_LAT-1:0] valid_q, owner_q;
    logic              f_gnt_c, l_gnt_c;
    logic              rd_in;

    always_comb begin
        f_gnt_c     = 1'b0;
        l_gnt_c     = 1'b0;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        if (state_q == StLock && l_req && l_lock) begin
            // Waiting fetch gets one slot once the loader has used its burst allowance.
            if (f_req && burst_cnt_q == MaxBurstC) begin
                f_gnt_c     = 1'b1;
                burst_cnt_d = 4'd0;
            end else begin
                l_gnt_c     = 1'b1;
                burst_cnt_d = (burst_cnt_q == MaxBurstC) ? MaxBurstC : burst_cnt_q + 4'd1;
            end
        end else begin
            state_d     = StArb;
            burst_cnt_d = 4'd0;
            if (f_req && l_req) begin
                if (last_owner_q == OwnLoader) f_gnt_c = 1'b1;
                else                           l_gnt_c = 1'b1;
            end else if (f_req) begin
                f_gnt_c = 1'b1;
            end else if (l_req) begin
                l_gnt_c = 1'b1;
            end
            if (l_gnt_c && l_lock) begin
                state_d     = StLock;
                burst_cnt_d = 4'd1;
            end
        end
    end

    // Grants are forced low while reset is asserted so the memory sees no access.
    assign f_gnt     = f_gnt_c & CLB;
    assign l_gnt     = l_gnt_c & CLB;
    assign mem_en    = f_gnt | l_gnt;
    assign mem_we    = l_gnt & l_we;
    assign mem_addr  = f_gnt ? f_addr : (l_gnt ? l_addr : '0);
    assign mem_wdata = (l_gnt && l_we) ? l_wdata : '0;
    assign rd_in     = f_gnt | (l_gnt & ~l_we);

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state_q      <= StArb;
            last_owner_q <= OwnLoader;
            burst_cnt_q  <= 4'd0;
            valid_q      <= '0;
            owner_q      <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            if (f_gnt) last_owner_q <= OwnFetch;
            if (l_gnt) last_owner_q <= OwnLoader;
            valid_q[0] <= rd_in;
            owner_q[0] <= l_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                owner_q[i] <= owner_q[i-1];
            end
        end
    end

    assign f_rvalid = valid_q[RD_LAT-1] & ~owner_q[RD_LAT-1];
    assign l_rvalid = valid_q[RD_LAT-1] & owner_q[RD_LAT-1];
    assign f_rdata  = f_rvalid ? mem_rdata : '0;
    assign l_rdata  = l_rvalid ? mem_rdata : '0;
    assign busy     = |valid_q;

`ifdef IMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            f_grant_cnt  <= 16'd0;
            l_grant_cnt  <= 16'd0;
            conflict_cnt <= 16'd0;
        end else begin
            if (f_gnt && f_grant_cnt != 16'hFFFF) f_grant_cnt <= f_grant_cnt + 16'd1;
            if (l_gnt && l_grant_cnt != 16'hFFFF) l_grant_cnt <= l_grant_cnt + 16'd1;
            if (f_req && l_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single-port program memory between the CPU instruction fetch path (driven by the controller's IR-load cycle) and the external program loader/debug port. Per-cycle arbitration: round-robin on conflict, plus a bounded loader lock for burst programming. Read data is routed back to the owning requester after a fixed memory latency. Sits between the controller/IR/PC datapath, the loader, and the memory macro.

Parameters:
AW, 8, address width
DW, 8, data width
RD_LAT, 1, memory read latency in cycles (legal 1..3)
MAX_BURST, 4, max consecutive loader grants under lock while fetch is waiting (legal 1..15)

Ports:
clk  in  1  system clock, rising edge
CLB  in  1  asynchronous active-low reset
f_req  in  1  fetch read request
f_addr  in  AW  fetch address (PC)
f_gnt  out  1  fetch request accepted this cycle (combinational)
f_rvalid  out  1  fetch read data valid
f_rdata  out  DW  fetch read data
l_req  in  1  loader request
l_we  in  1  loader write (1) / read (0)
l_lock  in  1  loader requests burst lock
l_addr  in  AW  loader address
l_wdata  in  DW  loader write data
l_gnt  out  1  loader request accepted this cycle (combinational)
l_rvalid  out  1  loader read data valid
l_rdata  out  DW  loader read data
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid RD_LAT cycles after mem_en read
busy  out  1  any read outstanding in return pipeline

Behaviour:
- Reset (CLB=0, async): state=ARB, last_owner=LOADER, burst_cnt=0, return pipeline cleared; all outputs 0. Outstanding reads are dropped (no rvalid after reset).
- At most one grant per cycle; a request counts as accepted only in a cycle with its gnt=1. Requester holds req/addr/data stable until granted.
- mem_en=f_gnt|l_gnt; mem_addr/mem_we/mem_wdata come from the granted requester; mem_we=l_gnt&l_we; all zero when idle.
- State ARB: only one req -> grant it. Both -> grant the one that is not last_owner. last_owner updates on every grant. Loader grant with l_lock=1 -> go to LOCK, burst_cnt=1.
- State LOCK: l_req&l_lock -> grant loader; burst_cnt++ . If f_req=1 and burst_cnt==MAX_BURST, grant fetch instead, set burst_cnt=0, stay LOCK. f_req=0: loader is not limited and burst_cnt saturates at MAX_BURST. l_lock=0 or l_req=0 -> back to ARB that cycle with normal ARB arbitration; burst_cnt=0.
- Return pipeline: RD_LAT-deep shift register of {valid, owner}. Shift in a 1 for a granted read; writes shift in 0. On exit, raise f_rvalid or l_rvalid for one cycle. Both rdata outputs = mem_rdata. rdata is don't-care when rvalid=0.
- Back-to-back reads are fully pipelined, so throughput is 1 access/cycle. Return order equals grant order.
- busy=1 while any pipeline entry is valid.
- Simultaneous loader write and fetch read of the same address: grant order decides. A read granted after the write returns the new data.

Optional Feature:
IMEM_ARB_STATS_EN: adds outputs f_grant_cnt[15:0], l_grant_cnt[15:0], conflict_cnt[15:0]. These are saturating counters for fetch grants, loader grants, and cycles with f_req&l_req. All reset to 0. Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then f_req only, f_addr=0x10, mem_rdata=0xA5 at RD_LAT=1 -> f_gnt same cycle, mem_addr=0x10, next cycle f_rvalid=1, f_rdata=0xA5, l_rvalid=0.
- f_req & l_req held 4 cycles, l_lock=0 -> grants alternate F,L,F,L (fetch first after reset).
- l_lock=1, l_we=1 writes to 0x00..0x07 with f_req held, MAX_BURST=4 -> L,L,L,L,F,L,L,L,L,F. Memory holds all 8 writes.
- Reads alternating F/L, RD_LAT=3 -> rvalids arrive 3 cycles after each grant, routed to the correct owner, busy high throughout.
- Assert CLB low with 2 reads outstanding -> all outputs 0 immediately, no rvalid after release, first conflict grants fetch.
- IMEM_ARB_STATS_EN: 5 conflict cycles -> conflict_cnt=5. Grant counters match the grant totals.
